pll_reset_sequencer: RTL and testbench

- Sits directly downstream of the ECP5 clock-generation PLL and consumes its asynchronous `locked` output.
- Runs on the PLL's 50 MHz output. Produces the core and peripheral/video resets for the CPU/GPU subsystem.
- Releases the resets in a staggered order only after lock has been continuously stable.
- Re-asserts both resets on a filtered loss of lock or a filtered user reset button, and counts lock-loss events for debug.

---
 rtl/pll_reset_sequencer_if.sv | 50 +++++
 rtl/pll_reset_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer_if
//
// Purpose:
//   Bundles the signals exchanged between the PLL reset sequencer and its
//   surroundings: the PLL lock flag and user button going in, and the staged
//   resets and debug status coming out.
//
// Signals:
//   pll_locked       PLL LOCK, asynchronous to the sequencer clock
//   btn_reset        user reset button, active-high, asynchronous
//   reset_core       active-high reset for the CPU/core domain
//   reset_periph     active-high reset for video/GPU/peripherals
//   ready            high when both resets are released
//   lock_loss_count  saturating count of filtered lock losses seen in RUN
//   state            debug: 0 WAIT_LOCK, 1 STABILIZE, 2 STAGGER, 3 RUN
//
// Modports:
//   master  the sequencer (consumes lock/button, drives resets/status)
//   slave   the environment (drives lock/button, consumes resets/status)
// -----------------------------------------------------------------------------
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       btn_reset;
    logic       reset_core;
    logic       reset_periph;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    modport master (
        input  pll_locked,
        input  btn_reset,
        output reset_core,
        output reset_periph,
        output ready,
        output lock_loss_count,
        output state
    );

    modport slave (
        output pll_locked,
        output btn_reset,
        input  reset_core,
        input  reset_periph,
        input  ready,
        input  lock_loss_count,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Generates the core and peripheral resets from the PLL lock flag. Lock must
//   be continuously present for LOCK_STABLE_CYCLES before reset_core releases,
//   and reset_periph/ready follow STAGGER_CYCLES later. A filtered loss of lock
//   while running (LOSS_FILTER consecutive unlocked cycles) or a filtered user
//   button press (BTN_FILTER consecutive cycles) sends everything back to
//   WAIT_LOCK. Filtered lock losses are counted (saturating at 255).
//
// Ports:
//   i_clock    PLL clk50 output, all logic on its rising edge
//   i_reset_n  asynchronous active-low block reset
//   io_seq     pll_reset_sequencer_if.master
//                in : pll_locked, btn_reset (both asynchronous)
//                out: reset_core, reset_periph, ready, lock_loss_count, state
//
// All outputs come straight from flops; the raw inputs are only seen by the
// synchroniser chains.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16,
    parameter int LOSS_FILTER        = 4,
    parameter int BTN_FILTER         = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    pll_reset_sequencer_if.master io_seq
);

    // The main counter is shared between STABILIZE and STAGGER, so it is
    // sized for the larger of the two intervals.
    localparam int MAIN_MAX = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                              LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W    = (MAIN_MAX    > 1) ? $clog2(MAIN_MAX)    : 1;
    localparam int LOSS_W   = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
    localparam int BTN_W    = (BTN_FILTER  > 1) ? $clog2(BTN_FILTER)  : 1;

    localparam logic [CNT_W-1:0]  LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [BTN_W-1:0]  BTN_LAST     = BTN_W'(BTN_FILTER - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_STAGGER   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   w_lock_s;
    logic                   w_btn_s;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], io_seq.pll_locked};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0],  io_seq.btn_reset};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Button filter: counts consecutive high cycles and parks at the last
    // value, so the request stays asserted for as long as the button is held.
    // ---------------------------------------------------------------------
    logic [BTN_W-1:0] r_btn_cnt;
    logic [BTN_W-1:0] w_btn_cnt_next;
    logic             w_btn_req;

    assign w_btn_req = w_btn_s && (r_btn_cnt == BTN_LAST);

    always_comb begin
        w_btn_cnt_next = '0;
        if (w_btn_s) begin
            w_btn_cnt_next = (r_btn_cnt == BTN_LAST) ? r_btn_cnt
                                                     : r_btn_cnt + BTN_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_btn_cnt <= '0;
        end else begin
            r_btn_cnt <= w_btn_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [LOSS_W-1:0] r_loss_cnt;
    logic [LOSS_W-1:0] w_loss_cnt_next;
    logic [7:0]        r_loss_count;
    logic [7:0]        w_loss_count_next;
    logic              w_loss_event;
    logic              r_reset_core;
    logic              r_reset_periph;
    logic              r_ready;

    // A loss that expires on the same edge as a button request is still
    // counted, so the event is evaluated independently of the button.
    assign w_loss_event = (r_state == ST_RUN) && !w_lock_s && (r_loss_cnt == LOSS_LAST);

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_loss_cnt_next   = '0;
        w_loss_count_next = r_loss_count;

        if (w_loss_event && (r_loss_count != 8'hFF)) begin
            w_loss_count_next = r_loss_count + 8'd1;
        end

        unique case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_next = '0;
                if (w_lock_s) begin
                    w_state_next = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_next = ST_STAGGER;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == STAGGER_LAST) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                w_cnt_next = '0;
                if (!w_lock_s) begin
                    if (w_loss_event) begin
                        w_state_next = ST_WAIT_LOCK;
                    end else begin
                        w_loss_cnt_next = r_loss_cnt + LOSS_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
                w_cnt_next   = '0;
            end
        endcase

        // The button overrides every other transition.
        if (w_btn_req) begin
            w_state_next    = ST_WAIT_LOCK;
            w_cnt_next      = '0;
            w_loss_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_WAIT_LOCK;
            r_cnt          <= '0;
            r_loss_cnt     <= '0;
            r_loss_count   <= '0;
            r_reset_core   <= 1'b1;
            r_reset_periph <= 1'b1;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_loss_cnt     <= w_loss_cnt_next;
            r_loss_count   <= w_loss_count_next;
            // Resets are registered from the next state so they change on
            // the same edge as the state transition.
            r_reset_core   <= (w_state_next == ST_WAIT_LOCK) ||
                              (w_state_next == ST_STABILIZE);
            r_reset_periph <= (w_state_next != ST_RUN);
            r_ready        <= (w_state_next == ST_RUN);
        end
    end

    assign io_seq.reset_core      = r_reset_core;
    assign io_seq.reset_periph    = r_reset_periph;
    assign io_seq.ready           = r_ready;
    assign io_seq.lock_loss_count = r_loss_count;
    assign io_seq.state           = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Drives pll_locked / btn_reset on falling clock edges and compares the DUT
// against a cycle model built from run lengths and phase entry times.
// Edge numbering inside a scenario: the rising edge just before an input is
// changed is edge 0, so the first edge able to sample the change is edge 1.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int STG  = 4;
    localparam int LOSS = 4;
    localparam int BTN  = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pll_reset_sequencer_if seq_if ();

    pll_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGGER_CYCLES     (STG),
        .LOSS_FILTER        (LOSS),
        .BTN_FILTER         (BTN)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_seq    (seq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------------
    // Reference model. Phases use the debug encoding 0..3.
    // ---------------------------------------------------------------------
    int m_lock_hist [SYNC];
    int m_btn_hist  [SYNC];
    int m_phase;
    int m_entry;
    int m_edge;
    int m_btn_run;
    int m_loss_run;
    int m_count;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            m_lock_hist[i] = 0;
            m_btn_hist[i]  = 0;
        end
        m_phase    = 0;
        m_entry    = 0;
        m_edge     = 0;
        m_btn_run  = 0;
        m_loss_run = 0;
        m_count    = 0;
    endtask

    task automatic model_step();
        int lock_s;
        int btn_s;
        int old_phase;
        bit btn_req;
        bit loss;
        // value the FSM sees now was sampled SYNC edges ago
        lock_s = m_lock_hist[SYNC-1];
        btn_s  = m_btn_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) begin
            m_lock_hist[i] = m_lock_hist[i-1];
            m_btn_hist[i]  = m_btn_hist[i-1];
        end
        m_lock_hist[0] = int'(seq_if.pll_locked);
        m_btn_hist[0]  = int'(seq_if.btn_reset);
        m_edge++;

        m_btn_run = btn_s ? m_btn_run + 1 : 0;
        btn_req   = (m_btn_run >= BTN);
        loss      = (m_phase == 3) && (lock_s == 0) && (m_loss_run + 1 >= LOSS);
        old_phase = m_phase;

        if (loss && m_count < 255) m_count++;

        if (btn_req || loss) begin
            m_phase = 0;
            m_entry = m_edge;
        end else begin
            case (m_phase)
                0: if (lock_s != 0) begin m_phase = 1; m_entry = m_edge; end
                1: if (lock_s == 0) begin m_phase = 0; m_entry = m_edge; end
                   else if (m_edge - m_entry == LSC) begin m_phase = 2; m_entry = m_edge; end
                2: if (lock_s == 0) begin m_phase = 0; m_entry = m_edge; end
                   else if (m_edge - m_entry == STG) begin m_phase = 3; m_entry = m_edge; end
                default: ;
            endcase
        end
        m_loss_run = (old_phase == 3 && m_phase == 3 && lock_s == 0) ? m_loss_run + 1 : 0;
    endtask

    function automatic logic [12:0] model_vec();
        return {2'(m_phase), (m_phase < 2), (m_phase != 3), (m_phase == 3), 8'(m_count)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {seq_if.state, seq_if.reset_core, seq_if.reset_periph,
                seq_if.ready, seq_if.lock_loss_count};
    endfunction

    // one rising edge (model follows it), returning at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n             = 1'b0;
        seq_if.pll_locked = 1'b1;
        seq_if.btn_reset  = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== 13'b00_1_1_0_00000000) begin
            n_bad++;
            $display("FAIL reset_values: got %b required %b", dut_vec(), 13'b00_1_1_0_00000000);
        end
        $display("reset: state=%0d core=%0d periph=%0d ready=%0d cnt=%0d",
                 seq_if.state, seq_if.reset_core, seq_if.reset_periph,
                 seq_if.ready, seq_if.lock_loss_count);
    endtask

    task automatic test_powerup();
        int exp_st;
        seq_if.pll_locked = 1'b0;
        rst_n = 1'b1;
        tick();                                  // edge 0
        seq_if.pll_locked = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_st = (k < 3) ? 0 : (k < 11) ? 1 : (k < 15) ? 2 : 3;
            n_cmp++;
            if (seq_if.state !== 2'(exp_st) || seq_if.reset_core !== (k < 11) ||
                seq_if.ready !== (k >= 15) || seq_if.reset_periph !== (k < 15)) begin
                n_bad++;
                $display("FAIL powerup_edge%0d: got st=%0d core=%0d periph=%0d ready=%0d required st=%0d core=%0d periph=%0d ready=%0d",
                         k, seq_if.state, seq_if.reset_core, seq_if.reset_periph, seq_if.ready,
                         exp_st, (k < 11), (k < 15), (k >= 15));
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL powerup_model edge%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        $display("powerup: state=%0d ready=%0d", seq_if.state, seq_if.ready);
    endtask

    task automatic test_glitch();
        seq_if.pll_locked = 1'b0;
        tick();
        tick();
        seq_if.pll_locked = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL glitch_model cyc%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (seq_if.state !== 2'd3 || seq_if.ready !== 1'b1 || seq_if.lock_loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL glitch_run: got st=%0d ready=%0d cnt=%0d required st=3 ready=1 cnt=0",
                     seq_if.state, seq_if.ready, seq_if.lock_loss_count);
        end
        $display("glitch: state=%0d ready=%0d cnt=%0d", seq_if.state, seq_if.ready, seq_if.lock_loss_count);
    endtask

    task automatic test_real_loss();
        seq_if.pll_locked = 1'b0;                // dropped after edge 0
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (seq_if.reset_core !== (k >= 6) || seq_if.reset_periph !== (k >= 6)) begin
                n_bad++;
                $display("FAIL loss_resets edge%0d: got core=%0d periph=%0d required %0d",
                         k, seq_if.reset_core, seq_if.reset_periph, (k >= 6));
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL loss_model edge%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (seq_if.lock_loss_count !== 8'd1) begin
            n_bad++;
            $display("FAIL loss_count: got %0d required 1", seq_if.lock_loss_count);
        end
        seq_if.pll_locked = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (seq_if.reset_core !== (k < 11) || seq_if.ready !== (k >= 15)) begin
                n_bad++;
                $display("FAIL relock_timing edge%0d: got core=%0d ready=%0d required core=%0d ready=%0d",
                         k, seq_if.reset_core, seq_if.ready, (k < 11), (k >= 15));
            end
        end
        $display("real_loss: cnt=%0d state=%0d", seq_if.lock_loss_count, seq_if.state);
    endtask

    task automatic test_unstable();
        logic [7:0] cnt_before;
        seq_if.pll_locked = 1'b0;                // real loss to reach WAIT_LOCK
        repeat (10) tick();
        cnt_before = seq_if.lock_loss_count;
        seq_if.pll_locked = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        seq_if.pll_locked = 1'b0;                // seen by the FSM at edge 9, counter 5
        for (int k = 7; k <= 12; k++) begin
            tick();
            n_cmp++;
            if (seq_if.state !== ((k < 9) ? 2'd1 : 2'd0) || seq_if.reset_core !== 1'b1) begin
                n_bad++;
                $display("FAIL unstable_drop edge%0d: got st=%0d core=%0d required st=%0d core=1",
                         k, seq_if.state, seq_if.reset_core, (k < 9) ? 1 : 0);
            end
        end
        n_cmp++;
        if (seq_if.lock_loss_count !== cnt_before) begin
            n_bad++;
            $display("FAIL unstable_count: got %0d required %0d", seq_if.lock_loss_count, cnt_before);
        end
        seq_if.pll_locked = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL unstable_model edge%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            if (k == 10 || k == 11) begin
                n_cmp++;
                if (seq_if.state !== ((k == 10) ? 2'd1 : 2'd2)) begin
                    n_bad++;
                    $display("FAIL unstable_restart edge%0d: got st=%0d required %0d",
                             k, seq_if.state, (k == 10) ? 1 : 2);
                end
            end
        end
        $display("unstable: state=%0d cnt=%0d", seq_if.state, seq_if.lock_loss_count);
    endtask

    task automatic test_button();
        logic [7:0] cnt_before;
        cnt_before = seq_if.lock_loss_count;
        seq_if.btn_reset = 1'b1;                 // short press: 3 cycles
        repeat (3) tick();
        seq_if.btn_reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (seq_if.state !== 2'd3 || seq_if.ready !== 1'b1) begin
                n_bad++;
                $display("FAIL btn_short cyc%0d: got st=%0d ready=%0d required st=3 ready=1",
                         k, seq_if.state, seq_if.ready);
            end
        end
        seq_if.btn_reset = 1'b1;                 // long press: 6 cycles
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6) seq_if.btn_reset = 1'b0;
            n_cmp++;
            if (seq_if.state !== ((k < 6) ? 2'd3 : (k < 9) ? 2'd0 : 2'd1)) begin
                n_bad++;
                $display("FAIL btn_long edge%0d: got st=%0d required %0d",
                         k, seq_if.state, (k < 6) ? 3 : (k < 9) ? 0 : 1);
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL btn_model edge%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (seq_if.lock_loss_count !== cnt_before) begin
            n_bad++;
            $display("FAIL btn_count: got %0d required %0d", seq_if.lock_loss_count, cnt_before);
        end
        $display("button: state=%0d cnt=%0d", seq_if.state, seq_if.lock_loss_count);
    endtask

    task automatic test_async_reset();
        // currently STABILIZE since button edge 9; STAGGER spans edges 17..20
        for (int k = 13; k <= 18; k++) tick();
        n_cmp++;
        if (seq_if.state !== 2'd2 || seq_if.reset_core !== 1'b0 || seq_if.lock_loss_count === 8'd0) begin
            n_bad++;
            $display("FAIL arst_setup: got st=%0d core=%0d cnt=%0d required st=2 core=0 cnt>0",
                     seq_if.state, seq_if.reset_core, seq_if.lock_loss_count);
        end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== 13'b00_1_1_0_00000000) begin
            n_bad++;
            $display("FAIL arst_immediate: got %b required %b", dut_vec(), 13'b00_1_1_0_00000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL arst_restart cyc%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        $display("async_reset: state=%0d cnt=%0d", seq_if.state, seq_if.lock_loss_count);
    endtask

    task automatic test_random();
        int lock_left;
        int btn_left;
        lock_left = 0;
        btn_left  = 0;
        for (int k = 0; k < 2000; k++) begin
            if (lock_left == 0) begin
                seq_if.pll_locked = ~seq_if.pll_locked;
                lock_left = seq_if.pll_locked ? $urandom_range(40, 1) : $urandom_range(12, 1);
            end
            lock_left--;
            if (btn_left == 0) begin
                seq_if.btn_reset = 1'b0;
                if ($urandom_range(15, 0) == 0) btn_left = $urandom_range(8, 1);
            end
            if (btn_left > 0) begin
                seq_if.btn_reset = 1'b1;
                btn_left--;
            end
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random_model cyc%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        seq_if.btn_reset = 1'b0;
        $display("random: state=%0d cnt=%0d", seq_if.state, seq_if.lock_loss_count);
    endtask

    task automatic test_saturation();
        seq_if.btn_reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            seq_if.pll_locked = 1'b1;
            repeat (17) tick();
            seq_if.pll_locked = 1'b0;
            repeat (8) tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL sat_model loss%0d: got %h required %h", n, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (seq_if.lock_loss_count !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_count: got %0d required 255", seq_if.lock_loss_count);
        end
        $display("saturation: cnt=%0d", seq_if.lock_loss_count);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_powerup();
        test_glitch();
        test_real_loss();
        test_unstable();
        test_button();
        test_async_reset();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
